// File: rtl/eth_txgen.sv
// Ethernet test-frame generator: emits fixed-header, counting-payload frames on a
// 64-bit AXI4-Stream master, singly or as a continuous train with inter-frame gaps.
module eth_txgen #(
    parameter logic [47:0] SRC_MAC   = 48'h00_11_22_33_44_55,
    parameter logic [47:0] DST_MAC   = 48'hFF_FF_FF_FF_FF_FF,
    parameter logic [15:0] ETHERTYPE = 16'h88B5
) (
    input  logic        clk156,
    input  logic        eth_rst_n,
    input  logic        start,
    input  logic        continuous,
    input  logic [10:0] frame_len,
    input  logic [7:0]  ifg_cycles,
    output logic        m_axis_tvalid,
    input  logic        m_axis_tready,
    output logic [63:0] m_axis_tdata,
    output logic [7:0]  m_axis_tkeep,
    output logic        m_axis_tlast,
    output logic        m_axis_tuser,
    output logic        busy,
    output logic [31:0] frame_cnt,
    output logic [7:0]  debug
);
    localparam logic [10:0] MIN_LEN = 11'd60;
    localparam logic [10:0] MAX_LEN = 11'd1514;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        HDR0    = 3'd1,
        HDR1    = 3'd2,
        PAYLOAD = 3'd3,
        GAP     = 3'd4
    } state_t;

    state_t      state_reg;
    logic [15:0] seq_reg;
    logic [31:0] frame_cnt_reg;
    logic [7:0]  beat_reg;
    logic [7:0]  last_idx_reg;
    logic [7:0]  last_keep_reg;
    logic [7:0]  ifg_reg;
    logic [7:0]  gap_cnt_reg;
    logic        tvalid_reg;
    logic        tlast_reg;
    logic [63:0] tdata_reg;
    logic [7:0]  tkeep_reg;

    logic [10:0] eff_len;
    logic [10:0] beats_w;
    logic [7:0]  start_last_idx;
    logic [7:0]  start_last_keep;

    always_comb begin
        eff_len = frame_len;
        if (frame_len < MIN_LEN) begin
            eff_len = MIN_LEN;
        end else if (frame_len > MAX_LEN) begin
            eff_len = MAX_LEN;
        end
        beats_w         = (eff_len + 11'd7) >> 3;
        start_last_idx  = beats_w[7:0] - 8'd1;
        start_last_keep = (eff_len[2:0] == 3'd0) ? 8'hFF : ~(8'hFF << eff_len[2:0]);
    end

    logic in_frame;
    logic accept;
    logic load_beat;
    logic [7:0]  nidx;
    logic        next_last;
    logic [7:0]  next_keep;
    logic [63:0] next_data;
    logic [63:0] hdr0_word;
    logic [63:0] hdr1_word;

    assign in_frame = (state_reg == HDR0) || (state_reg == HDR1) || (state_reg == PAYLOAD);
    assign accept   = tvalid_reg && m_axis_tready;

    // A new beat is staged on start, on every non-final accept, and when a train rolls over.
    assign load_beat = ((state_reg == IDLE) && start)
                    || (in_frame && accept && (!tlast_reg || ((ifg_reg == 8'd0) && continuous)))
                    || ((state_reg == GAP) && (gap_cnt_reg == 8'd0) && continuous);

    assign nidx      = (in_frame && !tlast_reg) ? (beat_reg + 8'd1) : 8'd0;
    // Frames are at least 8 beats, so the two header beats are never final.
    assign next_last = (nidx >= 8'd2) && (nidx == last_idx_reg);
    assign next_keep = next_last ? last_keep_reg : 8'hFF;

    assign hdr0_word = {SRC_MAC[39:32], SRC_MAC[47:40],
                        DST_MAC[7:0],   DST_MAC[15:8],  DST_MAC[23:16],
                        DST_MAC[31:24], DST_MAC[39:32], DST_MAC[47:40]};
    assign hdr1_word = {seq_reg[7:0],   seq_reg[15:8],
                        ETHERTYPE[7:0], ETHERTYPE[15:8],
                        SRC_MAC[7:0],   SRC_MAC[15:8],  SRC_MAC[23:16], SRC_MAC[31:24]};

    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_lane
            // Payload byte value is the low 8 bits of its frame offset (beat*8 + lane).
            assign next_data[8*gi +: 8] =
                (nidx == 8'd0) ? hdr0_word[8*gi +: 8] :
                (nidx == 8'd1) ? hdr1_word[8*gi +: 8] :
                next_keep[gi]  ? {nidx[4:0], 3'(gi)}  : 8'h00;
        end
    endgenerate

    always_ff @(posedge clk156 or negedge eth_rst_n) begin
        if (!eth_rst_n) begin
            state_reg     <= IDLE;
            seq_reg       <= 16'd0;
            frame_cnt_reg <= 32'd0;
            beat_reg      <= 8'd0;
            last_idx_reg  <= 8'd0;
            last_keep_reg <= 8'd0;
            ifg_reg       <= 8'd0;
            gap_cnt_reg   <= 8'd0;
            tvalid_reg    <= 1'b0;
            tlast_reg     <= 1'b0;
            tdata_reg     <= 64'd0;
            tkeep_reg     <= 8'd0;
        end else begin
            if (load_beat) begin
                tvalid_reg <= 1'b1;
                tdata_reg  <= next_data;
                tkeep_reg  <= next_keep;
                tlast_reg  <= next_last;
                beat_reg   <= nidx;
            end else if (accept && tlast_reg) begin
                tvalid_reg <= 1'b0;
                tlast_reg  <= 1'b0;
            end

            case (state_reg)
                IDLE: begin
                    if (start) begin
                        ifg_reg       <= ifg_cycles;
                        last_idx_reg  <= start_last_idx;
                        last_keep_reg <= start_last_keep;
                        state_reg     <= HDR0;
                    end
                end
                HDR0, HDR1, PAYLOAD: begin
                    if (accept) begin
                        if (tlast_reg) begin
                            frame_cnt_reg <= frame_cnt_reg + 32'd1;
                            seq_reg       <= seq_reg + 16'd1;
                            if (ifg_reg != 8'd0) begin
                                state_reg   <= GAP;
                                gap_cnt_reg <= ifg_reg - 8'd1;
                            end else begin
                                state_reg <= continuous ? HDR0 : IDLE;
                            end
                        end else begin
                            state_reg <= (nidx == 8'd1) ? HDR1 : PAYLOAD;
                        end
                    end
                end
                GAP: begin
                    if (gap_cnt_reg == 8'd0) begin
                        state_reg <= continuous ? HDR0 : IDLE;
                    end else begin
                        gap_cnt_reg <= gap_cnt_reg - 8'd1;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign m_axis_tvalid = tvalid_reg;
    assign m_axis_tdata  = tdata_reg;
    assign m_axis_tkeep  = tkeep_reg;
    assign m_axis_tlast  = tlast_reg;
    assign m_axis_tuser  = 1'b0;
    assign busy          = (state_reg != IDLE);
    assign frame_cnt     = frame_cnt_reg;
    assign debug         = {state_reg, seq_reg[4:0]};

endmodule

// File: tb/tb_eth_txgen.sv
// Self-checking bench for eth_txgen: byte-level frame model, per-cycle compare process,
// directed scenarios plus randomized trains with random back-pressure.
module tb_eth_txgen;
    logic        clk156 = 1'b0;
    logic        eth_rst_n;
    logic        start;
    logic        continuous;
    logic [10:0] frame_len;
    logic [7:0]  ifg_cycles;
    logic        tvalid;
    logic        tready;
    logic [63:0] tdata;
    logic [7:0]  tkeep;
    logic        tlast;
    logic        tuser;
    logic        busy;
    logic [31:0] frame_cnt;
    logic [7:0]  debug;

    always #5 clk156 = ~clk156;

    eth_txgen dut (
        .clk156(clk156), .eth_rst_n(eth_rst_n), .start(start), .continuous(continuous),
        .frame_len(frame_len), .ifg_cycles(ifg_cycles),
        .m_axis_tvalid(tvalid), .m_axis_tready(tready), .m_axis_tdata(tdata),
        .m_axis_tkeep(tkeep), .m_axis_tlast(tlast), .m_axis_tuser(tuser),
        .busy(busy), .frame_cnt(frame_cnt), .debug(debug)
    );

    localparam logic [47:0] SRC = 48'h00_11_22_33_44_55;
    localparam logic [47:0] DST = 48'hFF_FF_FF_FF_FF_FF;
    localparam logic [15:0] ETYPE = 16'h88B5;

    int checks = 0;
    int failures = 0;

    // Model state: current train parameters and progress through the current frame
    int          m_len;
    int          m_ifg;
    int          m_beat;
    int          m_seq;
    int unsigned m_fc;
    bit          rnd_ready;
    logic [63:0] cap_hdr0, cap_hdr1;
    int          cap_beats;
    logic [7:0]  cap_keep;
    int          last_gap;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int clamp_len(input int len);
        if (len < 60) return 60;
        if (len > 1514) return 1514;
        return len;
    endfunction

    function automatic logic [7:0] ref_byte(input int k, input int seq);
        logic [15:0] s;
        s = 16'(seq);
        if (k < 6)  return 8'(DST >> (8 * (5 - k)));
        if (k < 12) return 8'(SRC >> (8 * (11 - k)));
        if (k < 14) return 8'(ETYPE >> (8 * (13 - k)));
        if (k < 16) return 8'(s >> (8 * (15 - k)));
        return 8'(k);
    endfunction

    initial begin
        tready = 1'b1;
        forever begin
            @(posedge clk156);
            #1;
            tready = rnd_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
        end
    end

    initial begin : compare
        bit          prev_hold;
        logic [63:0] p_data;
        logic [7:0]  p_keep;
        logic        p_last;
        bit          after_tlast;
        int          gap, nb, k;
        logic [7:0]  ek;
        logic [63:0] ed, mask;
        prev_hold = 0;
        after_tlast = 0;
        gap = 0;
        forever begin
            @(negedge clk156);
            if (!eth_rst_n) begin
                m_beat = 0; m_seq = 0; m_fc = 0;
                prev_hold = 0; after_tlast = 0;
                continue;
            end
            chk("frame_cnt", frame_cnt, 64'(m_fc));
            chk("debug_seq", debug[4:0], 64'(m_seq[4:0]));
            chk("tuser", tuser, 0);
            if (after_tlast) begin
                if (tvalid) begin
                    chk("gap_len", gap, m_ifg);
                    chk("train_continue", continuous, 1);
                    last_gap = gap; after_tlast = 0;
                end else if (!busy) begin
                    chk("gap_len", gap, m_ifg);
                    chk("train_stop", continuous, 0);
                    last_gap = gap; after_tlast = 0;
                end else begin
                    gap++;
                    if (gap > 300) begin
                        chk("gap_timeout", gap, m_ifg);
                        after_tlast = 0;
                    end
                end
            end
            if (tvalid) chk("busy_with_tvalid", busy, 1);
            if (prev_hold) begin
                chk("hold_tvalid", tvalid, 1);
                chk("hold_tdata", tdata, p_data);
                chk("hold_tkeep", tkeep, p_keep);
                chk("hold_tlast", tlast, p_last);
            end
            prev_hold = tvalid && !tready;
            p_data = tdata; p_keep = tkeep; p_last = tlast;
            if (tvalid && tready) begin
                nb = (m_len + 7) / 8;
                ek = 0; ed = 0; mask = 0;
                for (int n = 0; n < 8; n++) begin
                    k = m_beat * 8 + n;
                    if (k < m_len) begin
                        ek[n] = 1'b1;
                        ed[8*n +: 8] = ref_byte(k, m_seq);
                        mask[8*n +: 8] = 8'hFF;
                    end
                end
                chk("beat_tdata", tdata & mask, ed);
                chk("beat_tkeep", tkeep, ek);
                chk("beat_tlast", tlast, m_beat == nb - 1);
                if (m_beat == 0) cap_hdr0 = tdata;
                if (m_beat == 1) cap_hdr1 = tdata;
                if (tlast) begin
                    cap_beats = m_beat + 1;
                    cap_keep = tkeep;
                    m_fc++;
                    m_seq = (m_seq + 1) & 16'hFFFF;
                    m_beat = 0;
                    after_tlast = 1;
                    gap = 0;
                end else begin
                    m_beat++;
                end
            end
        end
    end

    task automatic do_start(input int len, input int ifg, input bit cont);
        @(posedge clk156); #1;
        frame_len = 11'(len); ifg_cycles = 8'(ifg); continuous = cont; start = 1'b1;
        m_len = clamp_len(len); m_ifg = ifg;
        @(posedge clk156); #1;
        start = 1'b0;
        chk("start_tvalid", tvalid, 1);
        chk("start_busy", busy, 1);
        // A second start and new settings while busy must change nothing
        @(posedge clk156); #1;
        start = 1'b1; frame_len = 11'($urandom); ifg_cycles = 8'($urandom);
        @(posedge clk156); #1;
        start = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        do begin
            @(negedge clk156); #1;
            n++;
        end while (busy && n < budget);
        chk("wait_idle_busy", busy, 0);
    endtask

    task automatic wait_cont_stop(input int unsigned target, input int budget);
        int n;
        n = 0;
        do begin
            @(negedge clk156); #1;
            n++;
        end while (!(m_fc == target && m_beat >= 3) && n < budget);
        chk("cont_wait_in_budget", n < budget, 1);
        continuous = 1'b0;
    endtask

    initial begin : watchdog
        #3_000_000;
        failures++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int len, ifg, nf, n;
        int unsigned base;
        eth_rst_n = 1'b0; start = 1'b0; continuous = 1'b0;
        frame_len = '0; ifg_cycles = '0;
        m_len = 60; m_ifg = 0; m_beat = 0; m_seq = 0; m_fc = 0;
        rnd_ready = 0; last_gap = -1; cap_beats = 0;
        repeat (3) @(posedge clk156);
        #1;
        chk("rst_tvalid", tvalid, 0);
        chk("rst_tlast", tlast, 0);
        chk("rst_tkeep", tkeep, 0);
        chk("rst_tdata", tdata, 0);
        chk("rst_busy", busy, 0);
        chk("rst_frame_cnt", frame_cnt, 0);
        @(negedge clk156); #2;
        eth_rst_n = 1'b1;
        repeat (2) @(posedge clk156);
        #1;
        chk("idle_tvalid", tvalid, 0);

        // Single 64-byte frame, no back-pressure
        do_start(64, 0, 0);
        wait_idle(500);
        chk("v1_frame_cnt", frame_cnt, 1);
        chk("v1_beats", cap_beats, 8);
        chk("v1_last_keep", cap_keep, 8'hFF);
        chk("v1_hdr0", cap_hdr0, 64'h1100_FFFF_FFFF_FFFF);
        chk("v1_hdr1", cap_hdr1, 64'h0000_B588_5544_3322);

        do_start(61, 0, 0);
        wait_idle(500);
        chk("v2a_beats", cap_beats, 8);
        chk("v2a_last_keep", cap_keep, 8'h1F);
        do_start(10, 0, 0);
        wait_idle(500);
        chk("v2b_beats", cap_beats, 8);
        chk("v2b_last_keep", cap_keep, 8'h0F);

        rnd_ready = 1;
        do_start(100, 1, 0);
        wait_idle(1000);
        chk("v3_beats", cap_beats, 13);
        chk("v3_last_keep", cap_keep, 8'h0F);

        // Continuous train of four frames with a 3-cycle gap
        rnd_ready = 0;
        base = m_fc;
        do_start(64, 3, 1);
        wait_cont_stop(base + 3, 2000);
        wait_idle(1000);
        chk("v4_frame_cnt", frame_cnt, 8);
        chk("v4_last_gap", last_gap, 3);
        chk("v4_hdr1_seq7", cap_hdr1, 64'h0700_B588_5544_3322);

        rnd_ready = 1;
        do_start(1600, 0, 0);
        wait_idle(2000);
        chk("v6_beats", cap_beats, 190);
        chk("v6_last_keep", cap_keep, 8'h03);
        chk("v6_frame_cnt", frame_cnt, 9);

        for (int t = 0; t < 12; t++) begin
            len = (t % 3 == 0) ? $urandom_range(55, 130) : $urandom_range(0, 2047);
            ifg = $urandom_range(0, 4);
            nf = $urandom_range(1, 3);
            base = m_fc;
            do_start(len, ifg, nf > 1);
            if (nf > 1) wait_cont_stop(base + nf - 1, 5000);
            wait_idle(5000);
            chk("rand_train_frames", frame_cnt, 64'(base + nf));
        end

        // Reset in the middle of a frame's payload
        rnd_ready = 0;
        do_start(200, 2, 0);
        n = 0;
        do begin
            @(negedge clk156); #1;
            n++;
        end while (!(m_beat == 4 && tvalid) && n < 500);
        chk("v5_reach_beat4", n < 500, 1);
        #2;
        eth_rst_n = 1'b0;
        #1;
        chk("v5_rst_tvalid", tvalid, 0);
        chk("v5_rst_tlast", tlast, 0);
        chk("v5_rst_frame_cnt", frame_cnt, 0);
        chk("v5_rst_busy", busy, 0);
        repeat (2) @(negedge clk156);
        #2;
        eth_rst_n = 1'b1;
        do_start(64, 0, 0);
        wait_idle(500);
        chk("v5_post_frame_cnt", frame_cnt, 1);
        chk("v5_post_hdr1_seq0", cap_hdr1, 64'h0000_B588_5544_3322);
        chk("v5_post_beats", cap_beats, 8);

        repeat (3) @(posedge clk156);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
